// File: rtl/sqrt_rr_scheduler.sv
// Round-robin front end sharing one iterative 64-bit sqrt engine between NREQ requesters.
// Optional watchdog on the engine wait is compiled in with `define SQRT_TIMEOUT_EN.
module sqrt_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
`ifdef SQRT_TIMEOUT_EN
    ,
    parameter int unsigned TMO_CYC = 256
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_num,
    output logic [NREQ-1:0]      req_ready,
    output logic                 eng_start,
    output logic [63:0]          eng_num,
    input  logic                 eng_done,
    input  logic [31:0]          eng_root,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_root,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [63:0]       num_q, num_d;
    logic [31:0]       root_q, root_d;
    logic              start_q, start_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

`ifdef SQRT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    // Rotate requests so bit 0 is rr_ptr; the first set bit of the rotated vector wins.
    logic [2*NREQ-1:0] dbl_valid;
    logic [NREQ-1:0]   rot_valid;
    logic              found;
    logic [IDW-1:0]    win;
    logic [IDW:0]      sum;
    logic [63:0]       sel_num;

    assign dbl_valid = {req_valid, req_valid} >> rr_ptr_q;
    assign rot_valid = dbl_valid[NREQ-1:0];

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && rot_valid[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NREQ)) begin
                    sum = sum - (IDW+1)'(NREQ);
                end
                win = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_num   = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win == IDW'(i)) begin
                sel_num = req_num[64*i +: 64];
            end
            req_ready[i] = (state_q == StIdle) && found && (win == IDW'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        num_d    = num_q;
        root_d   = root_q;
        start_d  = 1'b0;
`ifdef SQRT_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d  = StIssue;
                    num_d    = sel_num;
                    id_d     = win;
                    rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                    start_d  = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef SQRT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (eng_done) begin
                    state_d = StResp;
                    root_d  = eng_root;
`ifdef SQRT_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TW'(TMO_CYC - 1)) begin
                    state_d = StResp;
                    root_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + TW'(1);
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        rsp_valid_d = (state_d == StResp);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            num_q       <= '0;
            root_q      <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SQRT_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            num_q       <= num_d;
            root_q      <= root_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef SQRT_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign eng_start = start_q;
    assign eng_num   = num_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_root  = root_q;
    assign busy      = busy_q;
`ifdef SQRT_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Directed bench for sqrt_rr_scheduler with a simple latency-programmable engine model.
module tb_sqrt_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req_valid;
    logic [255:0] req_num;
    logic [3:0]   req_ready;
    logic         eng_start;
    logic [63:0]  eng_num;
    logic         eng_done = 1'b0;
    logic [31:0]  eng_root = '0;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_root;
    logic         rsp_err;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Engine model
    int           eng_lat  = 10;
    logic         eng_mute = 1'b0;
    logic         eng_busy = 1'b0;
    int           eng_cnt  = 0;
    logic [63:0]  eng_op   = '0;

    always #5 clk = ~clk;

`ifdef SQRT_TIMEOUT_EN
    sqrt_rr_scheduler #(.NREQ(4), .IDW(2), .TMO_CYC(16)) dut (
`else
    sqrt_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_ready (req_ready),
        .eng_start (eng_start),
        .eng_num   (eng_num),
        .eng_done  (eng_done),
        .eng_root  (eng_root),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_root  (rsp_root),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    function automatic logic [31:0] isqrt(input logic [63:0] n);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= n) r = t;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_start) begin
            eng_cnt  <= eng_lat;
            eng_busy <= !eng_mute;
            eng_op   <= eng_num;
        end else if (eng_busy) begin
            if (eng_cnt <= 1) begin
                eng_done <= 1'b1;
                eng_root <= isqrt(eng_op);
                eng_busy <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the ISSUE cycle.
    task automatic issue_one(input int idx, input logic [63:0] num);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        req_valid = onehot;
        req_num[64*idx +: 64] = num;
        #1;
        chk("grant_onehot", {60'd0, req_ready}, {60'd0, onehot});
        @(negedge clk);
        chk("eng_start_pulse", {63'd0, eng_start}, 64'd1);
        chk("eng_num_operand", eng_num, num);
        chk("busy_in_issue", {63'd0, busy}, 64'd1);
        chk("no_grant_in_issue", {60'd0, req_ready}, 64'd0);
        req_valid = '0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_valid_arrives", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic take_rsp(input logic [1:0] id, input logic [31:0] root, input logic err);
        int c;
        wait_rsp(c);
        chk("rsp_id", {62'd0, rsp_id}, {62'd0, id});
        chk("rsp_root", {32'd0, rsp_root}, {32'd0, root});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, err});
        chk("no_grant_in_resp", {60'd0, req_ready}, 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drops", {63'd0, rsp_valid}, 64'd0);
        chk("idle_not_busy", {63'd0, busy}, 64'd0);
    endtask

    logic [1:0]  rr_ids   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] rr_roots [5] = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd2};
    logic [3:0]  rr_next  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        int c;
        req_valid = '0;
        req_num   = '0;
        rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_eng_start", {63'd0, eng_start}, 64'd0);
        chk("rst_eng_num", eng_num, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_rsp_root", {32'd0, rsp_root}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all four requesters held valid
        req_num   = {64'd25, 64'd16, 64'd9, 64'd4};
        req_valid = 4'hF;
        #1;
        chk("rr_first_grant", {60'd0, req_ready}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            take_rsp(rr_ids[i], rr_roots[i], 1'b0);
            chk("rr_next_grant", {60'd0, req_ready}, {60'd0, rr_next[i]});
        end
        req_valid = '0;
        @(negedge clk);

        // Single request
        issue_one(0, 64'd144);
        @(negedge clk);
        chk("eng_start_one_cycle", {63'd0, eng_start}, 64'd0);
        take_rsp(2'd0, 32'd12, 1'b0);

        // Boundary operands
        issue_one(1, 64'd0);
        take_rsp(2'd1, 32'd0, 1'b0);
        issue_one(2, 64'hFFFF_FFFF_FFFF_FFFF);
        take_rsp(2'd2, 32'hFFFF_FFFF, 1'b0);

        // Backpressure with a new request waiting
        issue_one(3, 64'd100);
        wait_rsp(c);
        req_num[127:64] = 64'd49;
        req_valid = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_id", {62'd0, rsp_id}, 64'd3);
            chk("bp_rsp_root", {32'd0, rsp_root}, 64'd10);
            chk("bp_no_grant", {60'd0, req_ready}, 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_rsp_valid_drops", {63'd0, rsp_valid}, 64'd0);
        chk("bp_grant_after_hs", {60'd0, req_ready}, 64'd2);
        @(negedge clk);
        chk("bp_next_start", {63'd0, eng_start}, 64'd1);
        chk("bp_next_num", eng_num, 64'd49);
        req_valid = '0;
        take_rsp(2'd1, 32'd7, 1'b0);

        // Reset while the engine is busy
        issue_one(2, 64'd64);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_eng_start", {63'd0, eng_start}, 64'd0);
        chk("mid_rst_eng_num", eng_num, 64'd0);
        chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("mid_rst_rsp_root", {32'd0, rsp_root}, 64'd0);
        chk("mid_rst_req_ready", {60'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("late_done_ignored", {63'd0, rsp_valid}, 64'd0);
        end
        req_valid = 4'hF;
        #1;
        chk("post_rst_grant_req0", {60'd0, req_ready}, 64'd1);
        @(negedge clk);
        chk("post_rst_num", eng_num, 64'd144);
        req_valid = '0;
        take_rsp(2'd0, 32'd12, 1'b0);

`ifdef SQRT_TIMEOUT_EN
        // Engine never answers: watchdog response, then normal service resumes
        eng_mute = 1'b1;
        issue_one(0, 64'd81);
        wait_rsp(c);
        chk("tmo_latency", 64'(c), 64'd17);
        chk("tmo_err", {63'd0, rsp_err}, 64'd1);
        chk("tmo_root", {32'd0, rsp_root}, 64'd0);
        chk("tmo_id", {62'd0, rsp_id}, 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        eng_mute = 1'b0;
        issue_one(1, 64'd81);
        take_rsp(2'd1, 32'd9, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule
